// File: rtl/board_io_ctrl.sv
// Board I/O controller: synchronised slide switches drive the LEDs (with a toggled invert)
// and a row of seven-segment digits showing the switch value, a fixed message or a scrolling message.
// Latency: switch -> leds/hex is 3 clock edges; key press -> state change takes about DEBOUNCE_CYCLES+3 edges.
// Backpressure: none; all outputs are registered and updated every cycle.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-high
//   switch[SW_W]   asynchronous slide switches
//   key[1:0]       asynchronous pushbuttons, pressed = 1 (key[0] invert, key[1] mode)
//   leds[SW_W]     registered LED drive
//   hex[8*NUM_HEX] registered active-low digits, digit i at [8i+7:8i] = {dp,g,f,e,d,c,b,a}
//
// Optional feature: define BOARD_IO_DP_EN to light the decimal point of digit 0 while invert is set.

module board_io_ctrl #(
    parameter int          SW_W            = 10,
    parameter int          NUM_HEX         = 6,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          SCROLL_DIV      = 25000000,
    parameter logic [31:0] MSG             = 32'h0021_0599
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SW_W-1:0]      switch,
    input  logic [1:0]           key,
    output logic [SW_W-1:0]      leds,
    output logic [8*NUM_HEX-1:0] hex
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCROLL_DIV - 1);
    localparam logic [2:0]       OFF_MAX = 3'(NUM_HEX - 1);

    typedef enum logic [1:0] {
        ST_HEXVAL = 2'd0,
        ST_MSG    = 2'd1,
        ST_SCROLL = 2'd2
    } mode_e;

    // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;
    logic [1:0]      key_s1_q, key_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '0;
            key_s2_q <= '0;
        end else begin
            sw_s1_q  <= switch;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers and press detection
    // ------------------------------------------------------------------
    logic [1:0] press;

    for (genvar k = 0; k < 2; k++) begin : g_db
        logic [DB_W-1:0] cnt_q;
        logic            lvl_q;
        logic            prev_q;

        // The counter only runs while the synced key disagrees with the
        // accepted level; any agreement (a bounce back) restarts the window.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
                prev_q <= 1'b0;
            end else begin
                prev_q <= lvl_q;
                if (key_s2_q[k] == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_MAX) begin
                    cnt_q <= '0;
                    lvl_q <= key_s2_q[k];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[k] = lvl_q & ~prev_q;
    end

    // ------------------------------------------------------------------
    // Invert flag and LED register
    // ------------------------------------------------------------------
    logic            invert_q;
    logic [SW_W-1:0] leds_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            invert_q <= 1'b0;
            leds_q   <= '0;
        end else begin
            if (press[0]) begin
                invert_q <= ~invert_q;
            end
            leds_q <= sw_s2_q ^ {SW_W{invert_q}};
        end
    end

    assign leds = leds_q;

    // ------------------------------------------------------------------
    // Mode FSM: state register / next state / digit outputs
    // ------------------------------------------------------------------
    mode_e mode_q, mode_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= ST_HEXVAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press[1]) begin
            case (mode_q)
                ST_HEXVAL: mode_d = ST_MSG;
                ST_MSG:    mode_d = ST_SCROLL;
                default:   mode_d = ST_HEXVAL;
            endcase
        end
    end

    // Scroll position. Holding both counters at zero outside SCROLL means
    // every entry into SCROLL starts from offset 0 with a full step period.
    logic [2:0]       off_q;
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_q <= '0;
            div_q <= '0;
        end else if (mode_q != ST_SCROLL) begin
            off_q <= '0;
            div_q <= '0;
        end else if (div_q == DIV_MAX) begin
            div_q <= '0;
            off_q <= (off_q == OFF_MAX) ? 3'd0 : off_q + 3'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    logic [3:0] msg_nib [8];
    for (genvar k = 0; k < 8; k++) begin : g_msg
        assign msg_nib[k] = MSG[4*k +: 4];
    end

    logic [8*NUM_HEX-1:0] hex_d;

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_dig
        localparam bit BLANK = (4*g >= SW_W);

        logic [3:0] sw_nib;
        logic [3:0] scr_sum;
        logic [3:0] nib;
        logic [7:0] seg_d;

        if (BLANK) begin : g_blank
            assign sw_nib = 4'h0;
        end else if (4*g + 4 <= SW_W) begin : g_full
            assign sw_nib = sw_s2_q[4*g +: 4];
        end else begin : g_part
            assign sw_nib = 4'(sw_s2_q[SW_W-1:4*g]);
        end

        always_comb begin
            // (g + offset) mod NUM_HEX; both operands are below NUM_HEX,
            // so one conditional subtraction is enough.
            scr_sum = 4'(g) + {1'b0, off_q};
            if (scr_sum >= 4'(NUM_HEX)) begin
                scr_sum = scr_sum - 4'(NUM_HEX);
            end

            case (mode_q)
                ST_MSG:    nib = msg_nib[g];
                ST_SCROLL: nib = msg_nib[scr_sum[2:0]];
                default:   nib = sw_nib;
            endcase

            if (BLANK && mode_q == ST_HEXVAL) begin
                seg_d = 8'hFF;
            end else begin
                seg_d = {1'b1, seg7(nib)};
            end
`ifdef BOARD_IO_DP_EN
            if (g == 0) begin
                seg_d[7] = ~invert_q;
            end
`endif
        end

        assign hex_d[8*g +: 8] = seg_d;
    end

    logic [8*NUM_HEX-1:0] hex_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q <= '1;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex = hex_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: directed stimulus pushes expected leds/hex into a
// scoreboard queue; a negedge monitor pops and compares against the outputs.
// Uses SW_W=10, NUM_HEX=6, DEBOUNCE_CYCLES=8, SCROLL_DIV=4.

module tb_board_io_ctrl;

    localparam int SW_W = 10;
    localparam int NH   = 6;
    localparam int DB   = 8;
    localparam int SD   = 4;

`ifdef BOARD_IO_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    // Hand-computed digit patterns, digit 0 in the low byte.
    localparam logic [47:0] HEX_ALL1 = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] HEX_0    = 48'hFFFF_FFC0_C0C0;
    localparam logic [47:0] HEX_2A5  = 48'hFFFF_FFA4_8892;
    localparam logic [47:0] HEX_3C7  = 48'hFFFF_FFB0_C6F8;

    // Segment codes of MSG 0x210599 nibbles 0..5: 9,9,5,0,1,2.
    logic [7:0] msg_seg [6] = '{8'h90, 8'h90, 8'h92, 8'hC0, 8'hF9, 8'hA4};

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  sw    = '0;
    logic [1:0]  key   = '0;
    logic [9:0]  leds;
    logic [47:0] hex;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .SW_W           (SW_W),
        .NUM_HEX        (NH),
        .DEBOUNCE_CYCLES(DB),
        .SCROLL_DIV     (SD),
        .MSG            (32'h0021_0599)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .switch(sw),
        .key   (key),
        .leds  (leds),
        .hex   (hex)
    );

    typedef struct {
        string       name;
        logic [9:0]  leds;
        logic [47:0] hex;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    // Monitor: compares every queued expectation at the next falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (leds !== mon_e.leds || hex !== mon_e.hex) begin
                n_err++;
                $display("FAIL %s: leds=%h hex=%h, expected leds=%h hex=%h",
                         mon_e.name, leds, hex, mon_e.leds, mon_e.hex);
            end
        end
    end

    task automatic sb_push(input string name, input logic [9:0] l, input logic [47:0] h);
        exp_t e;
        e.name = name;
        e.leds = l;
        e.hex  = h;
        sb.push_back(e);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [47:0] with_dp(input logic [47:0] h, input logic inv);
        logic [47:0] r;
        r = h;
        if (DP_EN && inv) r[7] = 1'b0;
        return r;
    endfunction

    function automatic logic [47:0] scroll_pat(input int off, input logic inv);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < NH; i++) begin
            r = r | (48'(msg_seg[3'((i + off) % NH)]) << (8 * i));
        end
        return with_dp(r, inv);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] m);
        key = m;
        tick(DB + 4);
        key = 2'b00;
        tick(DB + 6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          c;
        bit          found;
        int          lc, hc;
        logic [9:0]  l0;
        logic [47:0] h0;

        // Reset state
        tick(3);
        sb_push("reset_state", 10'h000, HEX_ALL1);
        reset = 1'b0;
        tick(4);
        sb_push("idle_hexval_zero", 10'h000, HEX_0);

        // Switch latency: nothing after 2 edges, new value after 3
        sw = 10'h2A5;
        tick(2);
        sb_push("latency_2_edges", 10'h000, HEX_0);
        tick(1);
        sb_push("latency_3_edges", 10'h2A5, HEX_2A5);

        // Short bounces must not toggle invert
        for (int r = 0; r < 5; r++) begin
            key = 2'b01;
            tick(DB - 2);
            key = 2'b00;
            tick(DB);
        end
        sb_push("bounce_ignored", 10'h2A5, HEX_2A5);

        // Invert press
        press(2'b01);
        sb_push("invert_on", 10'h15A, with_dp(HEX_2A5, 1'b1));

        // HEXVAL -> MSG
        press(2'b10);
        sb_push("mode_msg", 10'h15A, scroll_pat(0, 1'b1));

        // MSG -> SCROLL; msg pattern equals offset 0, so sync on offset 1
        key   = 2'b10;
        c     = 0;
        found = 1'b0;
        while (!found && c < 60) begin
            @(negedge clk);
            c++;
            if (c == DB + 4) key = 2'b00;
            if (hex === scroll_pat(1, 1'b1)) found = 1'b1;
        end
        chk_int("scroll_entry_seen", int'(found), 1);
        if (found) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            key = 2'b00;
            sb_push("scroll_off1", 10'h15A, scroll_pat(1, 1'b1));
            for (int k = 1; k <= 7; k++) begin
                tick(SD);
                sb_push($sformatf("scroll_step%0d", k), 10'h15A, scroll_pat((1 + k) % NH, 1'b1));
            end
        end
        key = 2'b00;
        tick(DB + 6);

        // SCROLL -> HEXVAL
        press(2'b10);
        sb_push("back_hexval", 10'h15A, with_dp(HEX_2A5, 1'b1));

        // Both keys together: invert and mode change on the same edge
        l0  = leds;
        h0  = hex;
        lc  = -1;
        hc  = -1;
        key = 2'b11;
        for (int k = 0; k < 4 * DB; k++) begin
            @(negedge clk);
            if (k == DB + 4) key = 2'b00;
            if (lc < 0 && leds !== l0) lc = k;
            if (hc < 0 && hex !== h0) hc = k;
        end
        key = 2'b00;
        chk_int("both_changed", int'(lc >= 0 && hc >= 0), 1);
        chk_int("both_same_cycle", hc, lc);
        tick(1);
        sb_push("both_result", 10'h2A5, scroll_pat(0, 1'b0));

        // Into SCROLL, start a debounce, then reset asynchronously
        press(2'b10);
        tick(5);
        key = 2'b01;
        tick(DB / 2);
        reset = 1'b1;
        sb_push("reset_mid_scroll", 10'h000, HEX_ALL1);
        key = 2'b00;
        tick(3);
        reset = 1'b0;
        tick(DB + 6);
        sb_push("post_reset", 10'h2A5, HEX_2A5);

        // Partial top nibble
        sw = 10'h3C7;
        tick(3);
        sb_push("switch_3c7", 10'h3C7, HEX_3C7);

        tick(2);
        chk_int("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
